// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a uart_tx: buffers pushed characters and launches
// them one at a time, waiting for the transmitter to go busy and then idle.
module uart_tx_fifo #(
   parameter int unsigned WORD_WIDTH = 8,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                    clock,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    wr_en,
   input  logic [WORD_WIDTH-1:0]   wr_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   input  logic                    tx_ready,
   output logic                    tx_data_valid,
   output logic [WORD_WIDTH-1:0]   tx_data_in
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam int unsigned CW      = AW + 1;
   localparam int unsigned TW      = 2;
   localparam int unsigned TIMEOUT = 4;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_LAUNCH    = 2'd1;
   localparam logic [1:0] S_WAIT_BUSY = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;

   logic [WORD_WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  full_q, empty_q;
   logic [1:0]            state_q, state_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  valid_q, valid_d;
   logic [WORD_WIDTH-1:0] data_q, data_d;
   logic                  push, pop, drop, mem_we;

   // Next-state logic for the buffer and the drain FSM; clear overrides all.
   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      valid_d    = 1'b0;
      data_d     = data_q;
      pop        = (state_q == S_LAUNCH) && !empty_q;
      push       = wr_en && (!full_q || pop);
      drop       = wr_en && full_q && !pop;
      mem_we     = push && !clear;
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      overflow_d = overflow_q | drop;

      case (state_q)
         S_IDLE: begin
            if (!empty_q && tx_ready) begin
               state_d = S_LAUNCH;
               valid_d = 1'b1;
               data_d  = mem_q[rd_ptr_q];
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT_BUSY;
            tmo_d   = '0;
         end
         S_WAIT_BUSY: begin
            // A launch the transmitter never took must not hang the drain.
            if (!tx_ready)                        state_d = S_WAIT_DONE;
            else if (tmo_q == TW'(TIMEOUT - 1))   state_d = S_IDLE;
            else                                  tmo_d   = tmo_q + TW'(1);
         end
         S_WAIT_DONE: begin
            if (tx_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         state_d    = S_IDLE;
         valid_d    = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         state_q    <= S_IDLE;
         tmo_q      <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         full_q     <= (count_d == CW'(DEPTH));
         empty_q    <= (count_d == '0);
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
      end
   end

   // Storage has no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clock) begin
      if (mem_we) mem_q[wr_ptr_q] <= wr_data;
   end

   assign full          = full_q;
   assign empty         = empty_q;
   assign count         = count_q;
   assign overflow      = overflow_q;
   assign tx_data_valid = valid_q;
   assign tx_data_in    = data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a per-cycle vector table plus hand-written
// sequences driven against a small uart_tx busy model.
module tb_uart_tx_fifo;

   logic       clock = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       tb_ready = 1'b0;
   logic       model_en = 1'b0;
   logic       tx_ready, model_ready;
   logic       full, empty, overflow, tx_data_valid;
   logic [4:0] count;
   logic [7:0] tx_data_in;
   logic [3:0] busy_cnt = 4'd0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int viol = 0;
   logic [7:0] pq[$];
   int         pc[$];

   uart_tx_fifo #(.WORD_WIDTH(8), .DEPTH(16)) dut (
      .clock(clock), .rst(rst), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .count(count), .overflow(overflow),
      .tx_ready(tx_ready), .tx_data_valid(tx_data_valid), .tx_data_in(tx_data_in)
   );

   always #5 clock = ~clock;

   // uart_tx model: goes busy for 10 cycles after each launch pulse.
   assign model_ready = (busy_cnt == 4'd0);
   assign tx_ready    = model_en ? model_ready : tb_ready;
   always @(posedge clock) begin
      if (tx_data_valid)        busy_cnt <= 4'd10;
      else if (busy_cnt != 4'd0) busy_cnt <= busy_cnt - 4'd1;
   end

   always @(negedge clock) begin
      cyc <= cyc + 1;
      if (tx_data_valid) begin
         pq.push_back(tx_data_in);
         pc.push_back(cyc);
         if ((model_en && !tx_ready) || empty) viol <= viol + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_pulses(input int n, input int budget, input string name);
      int k = 0;
      while (pq.size() < n && k < budget) begin
         @(negedge clock);
         k++;
      end
      chk(name, 32'(pq.size() >= n), 32'd1);
   endtask

   typedef struct packed {
      logic       wr;
      logic [7:0] wd;
      logic       rdy;
      logic       clr;
      logic       valid;
      logic [7:0] data;
      logic [4:0] cnt;
      logic       emp;
      logic       ful;
      logic       ovf;
   } vec_t;

   vec_t vecs [19];

   initial begin
      int base;
      logic [16:0] act, exp;

      //            wr  wd    rdy   clr   valid data  cnt   emp   ful   ovf
      vecs[0]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h5A, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22, 5'd1, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h22, 5'd0, 1'b1, 1'b0, 1'b0};
      vecs[17] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h22, 5'd0, 1'b1, 1'b0, 1'b0};
      vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h22, 5'd0, 1'b1, 1'b0, 1'b0};

      repeat (3) @(negedge clock);
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         @(negedge clock);
         act = {tx_data_valid, tx_data_in, count, empty, full, overflow};
         exp = {vecs[i].valid, vecs[i].data, vecs[i].cnt, vecs[i].emp, vecs[i].ful, vecs[i].ovf};
         chk($sformatf("vec%0d", i), 32'(act), 32'(exp));
         wr_en    = vecs[i].wr;
         wr_data  = vecs[i].wd;
         tb_ready = vecs[i].rdy;
         clear    = vecs[i].clr;
      end

      // Three back-to-back bytes against the busy model.
      @(negedge clock);
      model_en = 1'b1;
      base = pq.size();
      wr_en = 1'b1; wr_data = 8'h41;
      @(negedge clock); wr_data = 8'h42;
      @(negedge clock); wr_data = 8'h43;
      @(negedge clock); wr_en = 1'b0;
      wait_pulses(base + 3, 200, "seq3_pulses");
      for (int k = 0; k < 3; k++)
         chk($sformatf("seq3_data%0d", k), 32'(pq[base+k]), 32'(8'h41 + k));
      for (int k = 1; k < 3; k++)
         chk($sformatf("seq3_gap%0d", k), 32'((pc[base+k] - pc[base+k-1]) >= 12), 32'd1);

      // Overfill with the transmitter held busy, then drain.
      @(negedge clock);
      model_en = 1'b0; tb_ready = 1'b0; clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      for (int i = 0; i < 17; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h80 + i);
         @(negedge clock);
         if (i == 15) begin
            chk("fill_full", 32'(full), 32'd1);
            chk("fill_count", 32'(count), 32'd16);
            chk("fill_ovf_clear", 32'(overflow), 32'd0);
         end
      end
      wr_en = 1'b0;
      chk("drop_ovf", 32'(overflow), 32'd1);
      chk("drop_count", 32'(count), 32'd16);
      base = pq.size();
      model_en = 1'b1;
      wait_pulses(base + 16, 600, "drain16_pulses");
      repeat (40) @(negedge clock);
      chk("drain16_no_extra", 32'(pq.size()), 32'(base + 16));
      for (int k = 0; k < 16; k++)
         chk($sformatf("drain16_data%0d", k), 32'(pq[base+k]), 32'(8'h80 + k));
      chk("ovf_sticky", 32'(overflow), 32'd1);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0; model_en = 1'b0; tb_ready = 1'b0;
      chk("clear_ovf", 32'(overflow), 32'd0);
      chk("clear_empty", 32'(empty), 32'd1);

      // Push accepted while full because the launch pops in the same cycle.
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'hA0 + i);
         @(negedge clock);
      end
      wr_en = 1'b0;
      chk("full2", 32'(full), 32'd1);
      tb_ready = 1'b1;
      base = pq.size();
      @(negedge clock);
      chk("launch_when_full", 32'(tx_data_valid), 32'd1);
      wr_en = 1'b1; wr_data = 8'hC0; tb_ready = 1'b0;
      @(negedge clock);
      wr_en = 1'b0;
      chk("pushpop_count", 32'(count), 32'd16);
      chk("pushpop_full", 32'(full), 32'd1);
      chk("pushpop_ovf", 32'(overflow), 32'd0);
      model_en = 1'b1;
      wait_pulses(base + 17, 800, "drain17_pulses");
      for (int k = 0; k < 16; k++)
         chk($sformatf("drain17_data%0d", k), 32'(pq[base+k]), 32'(8'hA0 + k));
      chk("drain17_wrap", 32'(pq[base+16]), 32'h0000_00C0);

      // Reset with bytes queued and a frame in flight.
      @(negedge clock);
      model_en = 1'b0; tb_ready = 1'b0; clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h60 + i);
         @(negedge clock);
      end
      wr_en = 1'b0; tb_ready = 1'b1;
      @(negedge clock);
      tb_ready = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk("pre_rst_count", 32'(count), 32'd5);
      rst = 1'b1;
      #2;
      act = {tx_data_valid, tx_data_in, count, empty, full, overflow};
      chk("rst_outputs", 32'(act), 32'({1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0}));
      @(negedge clock);
      rst = 1'b0; tb_ready = 1'b1;
      base = pq.size();
      repeat (20) @(negedge clock);
      chk("rst_no_pulse", 32'(pq.size()), 32'(base));
      chk("rst_empty", 32'(empty), 32'd1);
      wr_en = 1'b1; wr_data = 8'h77;
      @(negedge clock);
      wr_en = 1'b0;
      chk("lat_cycle1", 32'(tx_data_valid), 32'd0);
      @(negedge clock);
      chk("lat_cycle2_valid", 32'(tx_data_valid), 32'd1);
      chk("lat_cycle2_data", 32'(tx_data_in), 32'h0000_0077);
      @(negedge clock);
      chk("pulse_single", 32'(tx_data_valid), 32'd0);
      repeat (4) @(negedge clock);
      chk("no_valid_violations", 32'(viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, bits per character.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of 2, at least 2.
REQ-003 SHALL have port clock, input, 1, rising-edge system clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port clear, input, 1, synchronous flush of FIFO and sticky flag.
REQ-006 SHALL have port wr_en, input, 1, push request.
REQ-007 SHALL have port wr_data, input, WORD_WIDTH, byte to push.
REQ-008 SHALL have port full, output, 1, high when count equals DEPTH.
REQ-009 SHALL have port empty, output, 1, high when count equals 0.
REQ-010 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-011 SHALL have port overflow, output, 1, sticky flag for a dropped push.
REQ-012 SHALL have port tx_ready, input, 1, uart_tx idle indication; low while a frame is in flight.
REQ-013 SHALL have port tx_data_valid, output, 1, one-cycle launch pulse to uart_tx.
REQ-014 SHALL have port tx_data_in, output, WORD_WIDTH, byte presented to uart_tx.

Function
REQ-015 SHALL store entries in a DEPTH-entry circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-016 SHALL accept a push when wr_en=1 and either full=0 or a pop occurs in the same cycle; the entry is visible in count on the next cycle.
REQ-017 SHALL drop a push when wr_en=1, full=1 and no same-cycle pop, leave contents unchanged, and set overflow on the next cycle.
REQ-018 SHALL, on clear=1, zero both pointers and count, clear overflow, and return the FSM to IDLE next cycle; clear overrides a same-cycle push or pop.
REQ-019 SHALL keep count unchanged when a push and a pop occur in the same cycle.
REQ-020 SHALL implement a drain FSM with states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
- IDLE -> LAUNCH when empty=0 and tx_ready=1.
- LAUNCH: register tx_data_in from the head entry, pulse tx_data_valid for exactly one cycle, and pop; -> WAIT_BUSY.
- WAIT_BUSY -> WAIT_DONE when tx_ready=0.
- WAIT_DONE -> IDLE when tx_ready=1.
REQ-021 SHALL return WAIT_BUSY to IDLE if tx_ready stays high for 4 consecutive cycles, so a missed launch cannot deadlock the FSM.
REQ-022 SHALL hold tx_data_in stable from the LAUNCH cycle until the next LAUNCH.
REQ-023 SHALL give a latency of 2 cycles from a push into an empty FIFO (with tx_ready=1 and the FSM in IDLE) to the tx_data_valid pulse.
REQ-024 SHALL never assert tx_data_valid while empty=1 or in any state other than LAUNCH.
REQ-025 SHALL derive full, empty and count from registered state only, with no combinational path from wr_en.

Reset
REQ-026 SHALL, while rst=1, asynchronously force the FSM to IDLE, pointers and count to 0, overflow=0, tx_data_valid=0 and tx_data_in=0; therefore empty=1 and full=0.
REQ-027 SHALL, on rst mid-frame, discard all queued bytes, issue no further tx_data_valid until a new push after rst deasserts, and leave the launched frame to uart_tx.

Verification
REQ-028 SHALL cover: push 0x5A into an empty FIFO with tx_ready=1 -> tx_data_valid pulses 2 cycles later with tx_data_in=0x5A, and count returns to 0.
REQ-029 SHALL cover: push 0x41, 0x42, 0x43 back-to-back, with the model dropping tx_ready for 10 cycles after each launch -> three single-cycle pulses in order 0x41, 0x42, 0x43, each only after tx_ready re-rises.
REQ-030 SHALL cover: tx_ready=0, push 17 bytes with DEPTH=16 -> full=1 after the 16th push, the 17th is dropped, overflow=1, and the drained sequence is the first 16 bytes.
REQ-031 SHALL cover: FIFO full while a pop occurs in the same cycle as a push -> push accepted, count stays 16, overflow stays 0.
REQ-032 SHALL cover: pulse rst while 5 bytes are queued and the FSM is in WAIT_DONE -> all outputs at reset values, and no tx_data_valid until a new push.
REQ-033 SHALL cover: tx_ready held at 1 after a launch -> the 4-cycle timeout returns the FSM to IDLE and the next byte launches.
